// File: rtl/ldpc_3gpp_dec_ibuf_ctrl.sv
// Multi-bank status controller for the LDPC decoder input LLR buffer (ping-pong for 2 banks).
// Optional statistics outputs (owerr, ofrm_cnt) are enabled by defining LDPC_3GPP_DEC_IBUF_STAT_EN.
module ldpc_3gpp_dec_ibuf_ctrl #(
    parameter int pBANK_NUM = 2,
    parameter int pADDR_W   = 8,
    parameter int pTAG_W    = 24
) (
    input  logic                                   iclk,
    input  logic                                   ireset,
    input  logic                                   iclkena,
    input  logic                                   iwrite,
    input  logic                                   iwfull,
    input  logic [pTAG_W-1:0]                      iwtag,
    output logic                                   owrdy,
    output logic [$clog2(pBANK_NUM)+pADDR_W-1:0]   owaddr,
    input  logic                                   irempty,
    output logic                                   ofull,
    output logic [$clog2(pBANK_NUM)-1:0]           orbank,
    output logic [pTAG_W-1:0]                      ortag
`ifdef LDPC_3GPP_DEC_IBUF_STAT_EN
    ,
    output logic                                   owerr,
    output logic [15:0]                            ofrm_cnt
`endif
);

    localparam int cBANK_W = $clog2(pBANK_NUM);
    localparam int cPTR_W  = cBANK_W + 1;

    logic [cPTR_W-1:0]  wptr;
    logic [cPTR_W-1:0]  rptr;
    logic [cPTR_W-1:0]  used;
    logic [pADDR_W-1:0] wcnt;
    logic [pTAG_W-1:0]  tag [pBANK_NUM];

    logic               wr_acc;
    logic               rel_acc;
    logic [cBANK_W-1:0] wbank;

    // Status flags decode registered pointers only, so no input reaches an output combinationally.
    always_comb begin
        used    = wptr - rptr;
        owrdy   = (used != cPTR_W'(pBANK_NUM));
        ofull   = (used != '0);
        wbank   = wptr[cBANK_W-1:0];
        orbank  = rptr[cBANK_W-1:0];
        owaddr  = {wbank, wcnt};
        ortag   = tag[orbank];
        wr_acc  = iwrite  & owrdy & iclkena;
        rel_acc = irempty & ofull & iclkena;
    end

    always_ff @(posedge iclk or posedge ireset) begin
        if (ireset) begin
            wptr <= '0;
            rptr <= '0;
            wcnt <= '0;
            tag  <= '{default: '0};
        end else begin
            if (wr_acc) begin
                if (iwfull) begin
                    tag[wbank] <= iwtag;
                    wptr       <= wptr + cPTR_W'(1);
                    wcnt       <= '0;
                end else begin
                    wcnt       <= wcnt + pADDR_W'(1);
                end
            end
            if (rel_acc) begin
                rptr <= rptr + cPTR_W'(1);
            end
        end
    end

`ifdef LDPC_3GPP_DEC_IBUF_STAT_EN
    always_ff @(posedge iclk or posedge ireset) begin
        if (ireset) begin
            owerr    <= 1'b0;
            ofrm_cnt <= '0;
        end else if (iclkena) begin
            if ((iwrite & ~owrdy) | (irempty & ~ofull)) begin
                owerr <= 1'b1;
            end
            if (wr_acc & iwfull) begin
                ofrm_cnt <= ofrm_cnt + 16'd1;
            end
        end
    end
`endif

endmodule
